// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the fixed-point complex arithmetic blocks.
//   state_t  : FSM encoding used by complex_div (IDLE, MUL, DIV, DONE)
//   DEF_W    : default signed operand/result width
//   DEF_FRAC : default number of fractional bits (Q2.14 at the defaults)
//   ONE      : the Q-format value of 1.0 at the default fraction width
// -----------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_W    = 16;
  localparam int DEF_FRAC = 14;
  localparam int ONE      = 1 << DEF_FRAC;

endpackage

// File: rtl/complex_div_udiv_seq.sv
// -----------------------------------------------------------------------------
// udiv_seq
// Iterative unsigned restoring divider, one quotient bit per enabled cycle,
// MSB first. The caller guarantees num < (den << QB), so QB steps give the
// exact floor(num / den).
//   clk, rst : clock and synchronous active-high reset
//   start    : first step; loads num/den and resolves the top quotient bit
//   en       : perform a step this cycle (must be high together with start)
//   num      : dividend (already scaled by the caller)
//   den      : divisor
//   quo      : quotient, valid after QB enabled cycles
// -----------------------------------------------------------------------------
module udiv_seq #(
  parameter int NW = 62,
  parameter int DW = 32,
  parameter int QB = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic [QB-1:0] quo
);

  logic [NW-1:0] rem;
  logic [NW-1:0] dsh;
  logic [NW-1:0] cur_rem;
  logic [NW-1:0] cur_d;
  logic          ge;

  // The start cycle works directly on the incoming operands so that no
  // separate load cycle is spent; later steps work on the held remainder
  // and the divisor shifted down one place per step.
  always_comb begin
    cur_rem = start ? num : rem;
    cur_d   = start ? (NW'(den) << (QB - 1)) : dsh;
    ge      = (cur_rem >= cur_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      dsh <= '0;
      quo <= '0;
    end else if (en) begin
      rem <= ge ? (cur_rem - cur_d) : cur_rem;
      dsh <= cur_d >> 1;
      quo <= start ? QB'(ge) : {quo[QB-2:0], ge};
    end
  end

endmodule

// File: rtl/complex_div.sv
// -----------------------------------------------------------------------------
// complex_div
// Fixed-point complex divide q = a / b = a * conj(b) / |b|^2, signed Q-format
// with FRAC fractional bits. One operation at a time, valid/ready on both sides.
//   i_clk, i_rst       : clock and synchronous active-high reset
//   i_ar, i_ai         : dividend a (real, imaginary)
//   i_br, i_bi         : divisor b (real, imaginary)
//   i_valid / o_ready  : operation handshake (o_ready high only when idle)
//   o_qr, o_qi         : quotient, truncated toward zero, symmetric saturation
//   o_valid / i_ready  : result handshake; result held until taken
//   o_sat              : at least one component saturated
//   o_div0             : divisor was zero (quotient forced to 0)
// Build option: define COMPLEX_DIV_ROUND_EN to compute one extra quotient bit
// and round half away from zero (one extra cycle of latency).
// Latency from accept to o_valid: W+1 (W+2 with rounding), 2 for a zero divisor.
// -----------------------------------------------------------------------------
module complex_div
  import fft_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic signed [W-1:0] i_ar,
  input  logic signed [W-1:0] i_ai,
  input  logic signed [W-1:0] i_br,
  input  logic signed [W-1:0] i_bi,
  input  logic                i_valid,
  output logic                o_ready,
  output logic signed [W-1:0] o_qr,
  output logic signed [W-1:0] o_qi,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sat,
  output logic                o_div0
);

`ifdef COMPLEX_DIV_ROUND_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int QB = W - 1 + RB;
  localparam int NW = 3 * W + FRAC;
  localparam int CW = $clog2(QB + 1);
  localparam logic [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};

  state_t              state;
  logic signed [W-1:0] ar, ai, br, bi;
  logic signed [2*W:0] nr, ni;
  logic [2*W-1:0]      den;
  logic                sat_r, sat_i;
  logic [CW-1:0]       cnt;

  logic signed [2*W:0]   nr_c, ni_c;
  logic signed [2*W-1:0] sq_r, sq_i;
  logic [2*W-1:0]        den_c;
  logic                  pre_r, pre_i;
  logic [QB-1:0]         quo_r, quo_i;
  logic [W:0]            fin_r, fin_i;
  logic                  div_start, div_en;

  // |n| scaled by 2^FRAC (and one more bit when rounding), zero-extended to
  // the divider width.
  function automatic logic [NW-1:0] mag_shift(input logic signed [2*W:0] n);
    logic [2*W:0] m;
    m = n[2*W] ? $unsigned(-n) : $unsigned(n);
    return NW'(m) << (FRAC + RB);
  endfunction

  // Turns a raw magnitude quotient into the signed, saturated result.
  // Returns {saturated, value}.
  function automatic logic [W:0] finalize(input logic [QB-1:0] q,
                                          input logic          pre_sat,
                                          input logic          neg);
    logic [W-1:0] mag;
    logic         sat;
    logic [W-1:0] val;
`ifdef COMPLEX_DIV_ROUND_EN
    logic [QB:0]  t;
    t   = {1'b0, q} + (QB+1)'(1);
    mag = W'(t >> 1);
`else
    mag = {1'b0, q};
`endif
    sat = pre_sat | mag[W-1];
    val = sat ? QMAX : mag;
    return {sat, neg ? -val : val};
  endfunction

  // Products are taken from the registered operands; den wraps into 2W bits
  // without loss because br^2 + bi^2 <= 2^(2W-1).
  assign nr_c  = (2*W+1)'(ar) * (2*W+1)'(br) + (2*W+1)'(ai) * (2*W+1)'(bi);
  assign ni_c  = (2*W+1)'(ai) * (2*W+1)'(br) - (2*W+1)'(ar) * (2*W+1)'(bi);
  assign sq_r  = (2*W)'(br) * (2*W)'(br);
  assign sq_i  = (2*W)'(bi) * (2*W)'(bi);
  assign den_c = $unsigned(sq_r) + $unsigned(sq_i);

  // A component saturates exactly when its scaled magnitude reaches
  // den << QB, i.e. its quotient would not fit in QB bits. Catching that here
  // keeps the divider's precondition true for every non-saturated component.
  assign pre_r = mag_shift(nr_c) >= (NW'(den_c) << QB);
  assign pre_i = mag_shift(ni_c) >= (NW'(den_c) << QB);

  assign div_en    = (state == DIV);
  assign div_start = div_en && (cnt == '0);

  udiv_seq #(.NW(NW), .DW(2*W), .QB(QB)) u_div_r (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (div_start),
    .en    (div_en),
    .num   (mag_shift(nr)),
    .den   (den),
    .quo   (quo_r)
  );

  udiv_seq #(.NW(NW), .DW(2*W), .QB(QB)) u_div_i (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (div_start),
    .en    (div_en),
    .num   (mag_shift(ni)),
    .den   (den),
    .quo   (quo_i)
  );

  assign fin_r = finalize(quo_r, sat_r, nr[2*W]);
  assign fin_i = finalize(quo_i, sat_i, ni[2*W]);

  assign o_ready = (state == IDLE);

  // Control FSM. DONE spends its first cycle registering the finished
  // quotient (o_valid still low) and then holds it until the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      ar      <= '0;
      ai      <= '0;
      br      <= '0;
      bi      <= '0;
      nr      <= '0;
      ni      <= '0;
      den     <= '0;
      sat_r   <= 1'b0;
      sat_i   <= 1'b0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_qr    <= '0;
      o_qi    <= '0;
      o_sat   <= 1'b0;
      o_div0  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            ar     <= i_ar;
            ai     <= i_ai;
            br     <= i_br;
            bi     <= i_bi;
            o_sat  <= 1'b0;
            o_div0 <= 1'b0;
            state  <= MUL;
          end
        end
        MUL: begin
          nr    <= nr_c;
          ni    <= ni_c;
          den   <= den_c;
          sat_r <= pre_r;
          sat_i <= pre_i;
          cnt   <= '0;
          state <= (den_c == '0) ? DONE : DIV;
        end
        DIV: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(QB - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!o_valid) begin
            if (den == '0) begin
              o_qr   <= '0;
              o_qi   <= '0;
              o_sat  <= 1'b0;
              o_div0 <= 1'b1;
            end else begin
              o_qr   <= $signed(fin_r[W-1:0]);
              o_qi   <= $signed(fin_i[W-1:0]);
              o_sat  <= fin_r[W] | fin_i[W];
              o_div0 <= 1'b0;
            end
            o_valid <= 1'b1;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// -----------------------------------------------------------------------------
// tb_complex_div
// Self-checking bench for complex_div at the default W=16, FRAC=14.
// A monitor compares the DUT against an arithmetic model of the quotient on
// every cycle; directed cases also pin captured results to literal values.
// Honours COMPLEX_DIV_ROUND_EN for the expected rounding and latency.
// -----------------------------------------------------------------------------
module tb_complex_div;
  import fft_pkg::*;

  localparam int W = 16;
`ifdef COMPLEX_DIV_ROUND_EN
  localparam int LAT   = W + 2;
  localparam bit ROUND = 1'b1;
`else
  localparam int LAT   = W + 1;
  localparam bit ROUND = 1'b0;
`endif
  localparam longint QMAX = 32767;

  logic                clk = 1'b0;
  logic                i_rst = 1'b1;
  logic signed [W-1:0] i_ar = '0, i_ai = '0, i_br = '0, i_bi = '0;
  logic                i_valid = 1'b0;
  logic                i_ready = 1'b0;
  logic                o_ready;
  logic signed [W-1:0] o_qr, o_qi;
  logic                o_valid;
  logic                o_sat;
  logic                o_div0;

  complex_div dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_ar    (i_ar),
    .i_ai    (i_ai),
    .i_br    (i_br),
    .i_bi    (i_bi),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_qr    (o_qr),
    .o_qi    (o_qi),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sat   (o_sat),
    .o_div0  (o_div0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, longint act, longint want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
  endfunction

  typedef struct {
    longint qr;
    longint qi;
    longint sat;
    longint div0;
  } res_t;

  // Reference: q = a*conj(b)/|b|^2 per component, magnitude floor (or
  // nearest, halves away from zero), symmetric clamp at 32767.
  function automatic res_t model(longint ar, longint ai, longint br, longint bi);
    res_t   r;
    longint n [2];
    longint den, m, q;
    n[0] = ar * br + ai * bi;
    n[1] = ai * br - ar * bi;
    den  = br * br + bi * bi;
    r    = '{0, 0, 0, 0};
    if (den == 0) begin
      r.div0 = 1;
      return r;
    end
    for (int k = 0; k < 2; k++) begin
      m = (n[k] < 0) ? -n[k] : n[k];
      if (ROUND) q = (2 * m * ONE + den) / (2 * den);
      else       q = (m * ONE) / den;
      if (q > QMAX) begin
        q     = QMAX;
        r.sat = 1;
      end
      if (n[k] < 0) q = -q;
      if (k == 0) r.qr = q;
      else        r.qi = q;
    end
    return r;
  endfunction

  // Monitor: tracks the one outstanding operation and checks the DUT every
  // cycle against what the model says the outputs must be.
  int     pending  = 0;
  int     seen     = 0;
  int     acc_edge = 0;
  int     exp_lat  = 0;
  res_t   want;
  int     cap_seen = 0;
  longint cap_qr, cap_qi, cap_sat, cap_div0;

  always @(negedge clk) begin
    if (i_rst) begin
      pending = 0;
      seen    = 0;
    end else begin
      check("o_valid", o_valid, (pending != 0) && (cyc - acc_edge >= exp_lat));
      check("o_ready", o_ready, pending == 0);
      if (o_valid && pending != 0) begin
        if (seen == 0) begin
          check("latency", cyc - acc_edge, exp_lat);
          seen = 1;
        end
        check("o_qr", o_qr, want.qr);
        check("o_qi", o_qi, want.qi);
        check("o_sat", o_sat, want.sat);
        check("o_div0", o_div0, want.div0);
        cap_qr   = o_qr;
        cap_qi   = o_qi;
        cap_sat  = o_sat;
        cap_div0 = o_div0;
        cap_seen = 1;
        if (i_ready) begin
          pending = 0;
          seen    = 0;
        end
      end else if (pending != 0 && cyc - acc_edge > exp_lat + 40) begin
        pending = 0;
      end
      if (i_valid && o_ready) begin
        want     = model(i_ar, i_ai, i_br, i_bi);
        pending  = 1;
        seen     = 0;
        acc_edge = cyc + 1;
        exp_lat  = (want.div0 != 0) ? 2 : LAT;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd16();
    logic [15:0] v;
    v = 16'($urandom);
    return int'($signed(v));
  endfunction

  // One full operation: wait for ready, present operands, scribble on the
  // inputs while busy, then hold i_ready low for 'hold' cycles in DONE.
  task automatic applyStimulus(input int ar, input int ai, input int br, input int bi,
                               input int hold);
    int guard;
    cap_seen = 0;
    guard    = 0;
    while (!o_ready && guard < 100) begin
      step();
      guard++;
    end
    i_ar    = 16'(ar);
    i_ai    = 16'(ai);
    i_br    = 16'(br);
    i_bi    = 16'(bi);
    i_valid = 1'b1;
    step();
    guard = 0;
    while (!o_valid && guard < 60) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ar    = 16'($urandom);
      i_ai    = 16'($urandom);
      i_br    = 16'($urandom);
      i_bi    = 16'($urandom);
      step();
      guard++;
    end
    i_valid = 1'b0;
    repeat (hold) step();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic checkOutput(string name, longint qr, longint qi, longint sat, longint div0);
    check({name, "_seen"}, cap_seen, 1);
    check({name, "_qr"}, cap_qr, qr);
    check({name, "_qi"}, cap_qi, qi);
    check({name, "_sat"}, cap_sat, sat);
    check({name, "_div0"}, cap_div0, div0);
  endtask

  task automatic applyReset(input int n);
    i_rst = 1'b1;
    repeat (n) step();
    i_rst = 1'b0;
  endtask

  task automatic checkReset(string name);
    check({name, "_ready"}, o_ready, 1);
    check({name, "_valid"}, o_valid, 0);
    check({name, "_qr"}, o_qr, 0);
    check({name, "_qi"}, o_qi, 0);
    check({name, "_sat"}, o_sat, 0);
    check({name, "_div0"}, o_div0, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ar, ai, br, bi, sel;
    $display("[TB] complex_div bench, latency %0d", LAT);
    applyReset(3);
    checkReset("reset");

    applyStimulus(16384, 0, 16384, 0, 5);
    checkOutput("unity", 16384, 0, 0, 0);
    applyStimulus(8192, 0, 0, 16384, 0);
    checkOutput("by_j", 0, -8192, 0, 0);
    applyStimulus(16384, 16384, 16384, 16384, 1);
    checkOutput("equal", 16384, 0, 0, 0);
    applyStimulus(16384, 0, 4096, 0, 0);
    checkOutput("sat_pos", 32767, 0, 1, 0);
    applyStimulus(-16384, 0, 4096, 0, 2);
    checkOutput("sat_neg", -32767, 0, 1, 0);
    applyStimulus(100, -5, 0, 0, 0);
    checkOutput("div0", 0, 0, 0, 1);
    applyStimulus(16384, 0, 24576, 0, 0);
    checkOutput("third", ROUND ? 10923 : 10922, 0, 0, 0);

    // Abort an operation mid-divide; no result may ever appear for it.
    i_ar    = 16'sd1000;
    i_ai    = 16'sd2000;
    i_br    = 16'sd3000;
    i_bi    = -16'sd4000;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (6) step();
    applyReset(1);
    checkReset("abort");
    repeat (LAT + 5) step();

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 3);
      ar  = rnd16();
      ai  = rnd16();
      br  = rnd16();
      bi  = rnd16();
      case (sel)
        1: begin
          br = $urandom_range(0, 400) - 200;
          bi = $urandom_range(0, 400) - 200;
        end
        2: begin
          if ($urandom_range(0, 1) == 1) begin
            br = 0;
            bi = 0;
          end else begin
            br = $urandom_range(0, 2) - 1;
            bi = 0;
            ar = $urandom_range(0, 4) - 2;
          end
        end
        3: begin
          ar = $urandom_range(0, 2000) - 1000;
          ai = $urandom_range(0, 2000) - 1000;
        end
        default: ;
      endcase
      applyStimulus(ar, ai, br, bi, $urandom_range(0, 3));
    end
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/complex_div.md
COMPLEX_DIV -- requirements
Module: complex_div

Interface
REQ-001 SHALL have parameter W, default 16, meaning signed operand/result width.
REQ-002 SHALL have parameter FRAC, default 14, meaning fractional bits (Q2.14 at defaults, 1.0 = 16384).
REQ-003 SHALL have port i_clk input 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst input 1: synchronous, active-high reset.
REQ-005 SHALL have ports i_ar, i_ai input W signed: dividend a, real and imaginary.
REQ-006 SHALL have ports i_br, i_bi input W signed: divisor b, real and imaginary.
REQ-007 SHALL have port i_valid input 1: the input operands are valid.
REQ-008 SHALL have port o_ready output 1: the block accepts an operation.
REQ-009 SHALL have ports o_qr, o_qi output W signed: quotient q = a/b.
REQ-010 SHALL have port o_valid output 1: the quotient is valid.
REQ-011 SHALL have port i_ready input 1: the downstream consumer takes the result.
REQ-012 SHALL have port o_sat output 1: at least one quotient component was saturated.
REQ-013 SHALL have port o_div0 output 1: the divisor was zero.

Function
REQ-014 SHALL compute q = a*conj(b)/|b|^2: nr = ar*br + ai*bi, ni = ai*br - ar*bi (2W+1 bits signed), den = br^2 + bi^2 (2W bits unsigned).
REQ-015 SHALL form each component as sign(n)*floor(|n|*2^FRAC/den), truncating toward zero.
REQ-016 SHALL saturate magnitudes >= 2^(W-1) to 2^(W-1)-1 (symmetric: +32767/-32767) and set o_sat.
REQ-017 SHALL use FSM states IDLE, MUL, DIV, DONE; o_ready = (state==IDLE).
REQ-018 SHALL accept an operation on an edge with i_valid && o_ready, register the operands, and go IDLE->MUL.
REQ-019 SHALL, in MUL (1 cycle), register nr/ni/den, run a saturation pre-check, and go to DIV, or to DONE if den==0.
REQ-020 SHALL, in DIV, resolve one magnitude bit per cycle for both components in parallel, for W-1 cycles, then go to DONE.
REQ-021 SHALL assert o_valid exactly W+1 cycles after the accepting edge (17 at defaults), or 2 cycles after it when den==0.
REQ-022 SHALL, in DONE, hold o_valid and o_qr/o_qi/o_sat/o_div0 stable until i_ready, then go DONE->IDLE on that edge.
REQ-023 SHALL therefore allow the next accept no earlier than the cycle after the handoff; i_valid outside IDLE is ignored.
REQ-024 SHALL, when den==0, output o_qr = o_qi = 0 with o_div0 = 1 and o_sat = 0.
REQ-025 SHALL clear o_sat and o_div0 at each accept.

Reset
REQ-026 SHALL, on i_rst, set state IDLE, o_valid 0, o_qr/o_qi 0, o_sat 0, o_div0 0, and o_ready 1 on the following cycle.
REQ-027 SHALL treat reset in MUL, DIV or DONE as aborting the operation; no o_valid pulse is produced for it.

Configuration
REQ-028 SHALL support macro COMPLEX_DIV_ROUND_EN; when defined, it adds one extra quotient bit and rounds half away from zero, adding 1 cycle of latency (W+2); saturation is applied after rounding.
REQ-029 SHALL, without COMPLEX_DIV_ROUND_EN, truncate per REQ-015 with latency W+1.

Structure
REQ-030 SHALL place the FSM state encoding, the default W/FRAC and the Q-format constant ONE = 2^FRAC in the shared package fft_pkg.
REQ-031 SHALL implement the iterative unsigned restoring-divide step as sub-module udiv_seq, instantiated twice (real and imaginary) sharing den.

Verification
REQ-032 SHALL cover: a=(16384,0), b=(16384,0) -> q=(16384,0), o_valid 17 cycles after accept, o_sat=0.
REQ-033 SHALL cover: a=(8192,0), b=(0,16384) -> q=(0,-8192); a=(16384,16384), b=(16384,16384) -> q=(16384,0).
REQ-034 SHALL cover: a=(16384,0), b=(4096,0) -> q=(32767,0), o_sat=1; a=(-16384,0), same b -> q=(-32767,0).
REQ-035 SHALL cover: b=(0,0), a=(100,-5) -> q=(0,0), o_div0=1, o_valid 2 cycles after accept.
REQ-036 SHALL cover: a=(16384,0), b=(24576,0) -> o_qr=10922, or 10923 with COMPLEX_DIV_ROUND_EN.
REQ-037 SHALL cover: i_ready held low 5 cycles in DONE -> outputs stable and o_ready 0; i_rst asserted in DIV -> no o_valid, o_ready 1 the cycle after reset.
